// File: rtl/hps_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hps_mailbox_pkg
// Description : Register map, STATUS/CONTROL bit positions and the bus address
//               width shared by the lightweight-bridge mailbox.
// Revision    : 1.0 - initial release
// ============================================================================
package hps_mailbox_pkg;

    localparam int C_ADDR_W = 2;

    localparam logic [C_ADDR_W-1:0] C_ADDR_DATA    = 2'd0;
    localparam logic [C_ADDR_W-1:0] C_ADDR_STATUS  = 2'd1;
    localparam logic [C_ADDR_W-1:0] C_ADDR_CONTROL = 2'd2;
    localparam logic [C_ADDR_W-1:0] C_ADDR_THRESH  = 2'd3;

    localparam int C_STAT_LEVEL_LSB = 0;
    localparam int C_STAT_LEVEL_W   = 8;
    localparam int C_STAT_EMPTY_BIT = 8;
    localparam int C_STAT_FULL_BIT  = 9;
    localparam int C_STAT_OVF_BIT   = 10;
    localparam int C_STAT_IRQP_BIT  = 11;

    localparam int C_CTRL_FLUSH_BIT   = 0;
    localparam int C_CTRL_IRQ_EN_BIT  = 1;
    localparam int C_CTRL_OVF_CLR_BIT = 2;

    localparam int C_THRESH_W = 8;

endpackage : hps_mailbox_pkg
`default_nettype wire

// File: rtl/hps_mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hps_mailbox_fifo
// Description : Show-ahead FIFO holding mailbox words; head entry is read
//               combinationally, flush clears level and pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module hps_mailbox_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr_q;
    logic [PTR_W-1:0]  r_rd_ptr_q;
    logic [LVL_W-1:0]  r_level_q;
    logic [PTR_W-1:0]  w_wr_ptr_d;
    logic [PTR_W-1:0]  w_rd_ptr_d;
    logic [LVL_W-1:0]  w_level_d;
    logic              w_pop;
    logic              w_push;

    assign full  = (r_level_q == LVL_W'(DEPTH));
    assign empty = (r_level_q == '0);
    assign level = r_level_q;
    assign rdata = r_mem_q[r_rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop) & ~flush;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                w_level_d = r_level_q + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                w_level_d = r_level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    // Storage is not reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= wdata;
        end
    end

endmodule : hps_mailbox_fifo
`default_nettype wire

// File: rtl/hps_lw_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : hps_lw_mailbox
// Description : HPS lightweight-bridge mailbox: Avalon-MM register slave that
//               pushes words into a FIFO drained by an Avalon-ST source.
//               Optional watermark interrupt enabled by HPS_MAILBOX_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hps_lw_mailbox
    import hps_mailbox_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [C_ADDR_W-1:0] avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                aso_valid,
    input  logic                aso_ready,
    output logic [DATA_W-1:0]   aso_data,
    output logic                irq
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             w_wr_data;
    logic             w_wr_ctrl;
    logic             w_flush;
    logic             w_ovf_clr;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf_evt;
    logic [LVL_W-1:0] w_level;
    logic [7:0]       w_level8;
    logic             r_ovf_q;
    logic             w_ovf_d;
    logic [31:0]      r_rdata_q;
    logic [31:0]      w_rdata_d;
    logic [31:0]      w_status;
    logic [31:0]      w_control;
    logic             w_irq_en;
    logic             w_irq_pending;
    logic [7:0]       w_thresh;

    assign w_wr_data = avs_write && (avs_address == C_ADDR_DATA);
    assign w_wr_ctrl = avs_write && (avs_address == C_ADDR_CONTROL);
    assign w_flush   = w_wr_ctrl && avs_writedata[C_CTRL_FLUSH_BIT];
    assign w_ovf_clr = w_wr_ctrl && avs_writedata[C_CTRL_OVF_CLR_BIT];

    assign aso_valid = ~w_empty;
    assign w_pop     = ~w_empty & aso_ready;
    assign w_level8  = 8'(w_level);

    hps_mailbox_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_wr_data),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (avs_writedata[DATA_W-1:0]),
        .rdata (aso_data),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    // An overflow in the same cycle as OVF_CLR keeps the flag set.
    assign w_ovf_evt = w_wr_data & w_full & ~w_pop;

    always_comb begin
        w_ovf_d = r_ovf_q;
        if (w_ovf_clr) begin
            w_ovf_d = 1'b0;
        end
        if (w_ovf_evt) begin
            w_ovf_d = 1'b1;
        end
    end

`ifdef HPS_MAILBOX_IRQ_EN
    logic       w_wr_thresh;
    logic       r_irq_en_q;
    logic       w_irq_en_d;
    logic [7:0] r_thresh_q;
    logic [7:0] w_thresh_d;
    logic       r_irq_pending_q;
    logic       r_irq_q;
    logic       w_below;

    assign w_wr_thresh = avs_write && (avs_address == C_ADDR_THRESH);
    assign w_irq_en_d  = w_wr_ctrl ? avs_writedata[C_CTRL_IRQ_EN_BIT] : r_irq_en_q;
    assign w_thresh_d  = w_wr_thresh ? avs_writedata[C_THRESH_W-1:0] : r_thresh_q;
    assign w_below     = (w_level8 <= r_thresh_q);

    // irq uses the next IRQ_EN so a disable takes effect on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en_q      <= 1'b0;
            r_thresh_q      <= '0;
            r_irq_pending_q <= 1'b0;
            r_irq_q         <= 1'b0;
        end else begin
            r_irq_en_q      <= w_irq_en_d;
            r_thresh_q      <= w_thresh_d;
            r_irq_pending_q <= w_below;
            r_irq_q         <= w_irq_en_d & w_below;
        end
    end

    assign w_irq_en      = r_irq_en_q;
    assign w_thresh      = r_thresh_q;
    assign w_irq_pending = r_irq_pending_q;
    assign irq           = r_irq_q;
`else
    assign w_irq_en      = 1'b0;
    assign w_thresh      = '0;
    assign w_irq_pending = 1'b0;
    assign irq           = 1'b0;
`endif

    always_comb begin
        w_status = '0;
        w_status[C_STAT_LEVEL_LSB +: C_STAT_LEVEL_W] = w_level8;
        w_status[C_STAT_EMPTY_BIT] = w_empty;
        w_status[C_STAT_FULL_BIT]  = w_full;
        w_status[C_STAT_OVF_BIT]   = r_ovf_q;
        w_status[C_STAT_IRQP_BIT]  = w_irq_pending;
    end

    always_comb begin
        w_control = '0;
        w_control[C_CTRL_IRQ_EN_BIT] = w_irq_en;
    end

    // Read mux sees only current-state registers, so a same-cycle write is not visible.
    always_comb begin
        w_rdata_d = '0;
        case (avs_address)
            C_ADDR_STATUS:  w_rdata_d = w_status;
            C_ADDR_CONTROL: w_rdata_d = w_control;
            C_ADDR_THRESH:  w_rdata_d = {24'h0, w_thresh};
            default:        w_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_q   <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            r_ovf_q <= w_ovf_d;
            if (avs_read) begin
                r_rdata_q <= w_rdata_d;
            end
        end
    end

    assign avs_readdata = r_rdata_q;

endmodule : hps_lw_mailbox
`default_nettype wire

// File: tb/tb_hps_lw_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_hps_lw_mailbox
// Description : Self-checking bench for hps_lw_mailbox with a queue-based
//               reference model and randomized bus/stream traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hps_lw_mailbox;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
`ifdef HPS_MAILBOX_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif
    localparam logic [31:0] IRQP_BIT = IRQ_BUILD ? 32'h800 : 32'h0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        avs_address = '0;
    logic              avs_read = 1'b0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic              aso_valid;
    logic              aso_ready = 1'b0;
    logic [DATA_W-1:0] aso_data;
    logic              irq;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] q[$];
    logic        m_ovf, m_irq_en, m_irqp, m_irq;
    logic [7:0]  m_thresh;
    logic [31:0] m_rdata;

    hps_lw_mailbox #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .aso_valid     (aso_valid),
        .aso_ready     (aso_ready),
        .aso_data      (aso_data),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            2'd1: begin
                v[7:0] = 8'(q.size());
                v[8]   = (q.size() == 0);
                v[9]   = (q.size() == DEPTH);
                v[10]  = m_ovf;
                v[11]  = m_irqp;
            end
            2'd2: v[1] = m_irq_en;
            2'd3: v[7:0] = m_thresh;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        logic pend, evt;
        if (reset) begin
            q.delete();
            m_ovf = 0; m_irq_en = 0; m_thresh = 0;
            m_irqp = 0; m_irq = 0; m_rdata = 0;
            return;
        end
        pend = (q.size() <= int'(m_thresh));
        if (avs_read) m_rdata = reg_value(avs_address);
        if (q.size() != 0 && aso_ready) void'(q.pop_front());
        evt = 1'b0;
        if (avs_write) begin
            case (avs_address)
                2'd0: if (q.size() < DEPTH) q.push_back(avs_writedata); else evt = 1'b1;
                2'd2: begin
                    if (avs_writedata[0]) q.delete();
                    if (avs_writedata[2]) m_ovf = 1'b0;
                    if (IRQ_BUILD) m_irq_en = avs_writedata[1];
                end
                2'd3: if (IRQ_BUILD) m_thresh = avs_writedata[7:0];
                default: ;
            endcase
        end
        if (evt) m_ovf = 1'b1;
        m_irqp = IRQ_BUILD && pend;
        m_irq  = IRQ_BUILD && m_irq_en && pend;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        step();
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        avs_read = 1'b1; avs_address = a;
        step();
        avs_read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_cmp++; if (aso_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", aso_valid); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
        n_cmp++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", avs_readdata); end
        reset = 1'b0;
        n_cmp++; if (aso_valid !== 1'b0 || irq !== 1'b0 || avs_readdata !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_outputs got=%b/%b/%h exp=0/0/0", aso_valid, irq, avs_readdata);
        end
        step();
        bus_read(2'd1);
        n_cmp++; if (avs_readdata !== (32'h100 | IRQP_BIT)) begin
            n_fail++; $display("FAIL reset_status got=%h exp=%h", avs_readdata, 32'h100 | IRQP_BIT);
        end
    endtask

    task automatic test_overflow();
        aso_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h11 + 32'(i));
        bus_read(2'd1);
        n_cmp++; if (avs_readdata !== 32'h210) begin n_fail++; $display("FAIL full_status got=%h exp=00000210", avs_readdata); end
        bus_write(2'd0, 32'hDEAD);
        bus_read(2'd1);
        n_cmp++; if (avs_readdata !== 32'h610) begin n_fail++; $display("FAIL ovf_status got=%h exp=00000610", avs_readdata); end
        aso_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (aso_valid !== 1'b1 || aso_data !== 32'h11 + 32'(i)) begin
                n_fail++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, aso_valid, aso_data, 32'h11 + 32'(i));
            end
            step();
        end
        aso_ready = 1'b0;
        n_cmp++; if (aso_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", aso_valid); end
        bus_write(2'd2, 32'h4);
        step();
        bus_read(2'd1);
        n_cmp++; if (avs_readdata !== (32'h100 | IRQP_BIT)) begin
            n_fail++; $display("FAIL ovf_clr_status got=%h exp=%h", avs_readdata, 32'h100 | IRQP_BIT);
        end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] words [16];
        aso_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom;
            bus_write(2'd0, words[i]);
        end
        aso_ready = 1'b1;
        bus_write(2'd0, 32'hCAFE0001);
        aso_ready = 1'b0;
        bus_read(2'd1);
        n_cmp++; if (avs_readdata !== 32'h210) begin n_fail++; $display("FAIL pushpop_status got=%h exp=00000210", avs_readdata); end
        n_cmp++; if (aso_data !== words[1]) begin n_fail++; $display("FAIL pushpop_head got=%h exp=%h", aso_data, words[1]); end
        bus_write(2'd2, 32'h1);
        n_cmp++; if (aso_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_flush got=%b exp=0", aso_valid); end
    endtask

    task automatic test_irq();
        int pre;
        bus_write(2'd3, 32'h2);
        bus_write(2'd2, 32'h2);
        aso_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(2'd0, $urandom);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got=%b exp=0", irq); end
        aso_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pre = q.size();
            step();
            n_cmp++; if (irq !== (pre <= 2)) begin n_fail++; $display("FAIL irq_drain_%0d got=%b exp=%b", i, irq, pre <= 2); end
        end
        aso_ready = 1'b0;
        bus_write(2'd2, 32'h0);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disable got=%b exp=0", irq); end
    endtask

    task automatic test_irq_regs();
        bus_write(2'd3, 32'h1FF);
        bus_write(2'd2, 32'h2);
        bus_read(2'd3);
        n_cmp++; if (avs_readdata !== (IRQ_BUILD ? 32'hFF : 32'h0)) begin
            n_fail++; $display("FAIL thresh_rd got=%h exp=%h", avs_readdata, IRQ_BUILD ? 32'hFF : 32'h0);
        end
        bus_read(2'd2);
        n_cmp++; if (avs_readdata !== (IRQ_BUILD ? 32'h2 : 32'h0)) begin
            n_fail++; $display("FAIL ctrl_rd got=%h exp=%h", avs_readdata, IRQ_BUILD ? 32'h2 : 32'h0);
        end
        step();
        n_cmp++; if (irq !== IRQ_BUILD) begin n_fail++; $display("FAIL irq_regs_irq got=%b exp=%b", irq, IRQ_BUILD); end
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h0);
    endtask

    task automatic test_flush();
        aso_ready = 1'b0;
        for (int i = 0; i < 7; i++) bus_write(2'd0, $urandom);
        aso_ready = 1'b1;
        bus_write(2'd2, 32'h1);
        aso_ready = 1'b0;
        n_cmp++; if (aso_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", aso_valid); end
        bus_read(2'd1);
        n_cmp++; if (avs_readdata !== 32'h100) begin n_fail++; $display("FAIL flush_status got=%h exp=00000100", avs_readdata); end
    endtask

    task automatic test_mid_reset();
        aso_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, $urandom);
        aso_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        aso_ready = 1'b0;
        n_cmp++; if (aso_valid !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL midreset_out got=%b/%b exp=0/0", aso_valid, irq);
        end
        step();
        bus_read(2'd1);
        n_cmp++; if (avs_readdata !== (32'h100 | IRQP_BIT)) begin
            n_fail++; $display("FAIL midreset_status got=%h exp=%h", avs_readdata, 32'h100 | IRQP_BIT);
        end
    endtask

    task automatic test_random();
        int op;
        logic did_read;
        for (int c = 0; c < 600; c++) begin
            aso_ready   = ($urandom_range(0, 2) < (c < 300 ? 1 : 2));
            op          = $urandom_range(0, 9);
            did_read    = ($urandom_range(0, 3) == 0);
            avs_read    = did_read;
            avs_write   = 1'b0;
            avs_address = 2'($urandom_range(0, 3));
            if (op <= 4) begin
                avs_write = 1'b1; avs_address = 2'd0; avs_writedata = $urandom;
            end else if (op == 6) begin
                avs_write = 1'b1; avs_address = 2'd2;
                avs_writedata = {29'h0, 3'($urandom_range(0, 7))} & (($urandom_range(0, 3) == 0) ? 32'h7 : 32'h6);
            end else if (op == 7) begin
                avs_write = 1'b1; avs_address = 2'd3; avs_writedata = 32'($urandom_range(0, 20));
            end
            step();
            avs_read = 1'b0; avs_write = 1'b0;
            n_cmp++; if (aso_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, aso_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_cmp++; if (aso_data !== q[0]) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, aso_data, q[0]); end
            end
            n_cmp++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, m_irq); end
            if (did_read) begin
                n_cmp++; if (avs_readdata !== m_rdata) begin
                    n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, avs_readdata, m_rdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_push_pop_full();
        test_irq_regs();
`ifdef HPS_MAILBOX_IRQ_EN
        test_irq();
`endif
        test_flush();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_hps_lw_mailbox
`default_nettype wire
